// File: rtl/ring_code_monitor.sv
// ring_code_monitor
// Watches a sampled ring-counter code and tracks whether it is stepping
// correctly (one-hot, rotating left by one position per qualified sample).
// The monitor hunts for a valid one-hot code, confirms LOCK_CNT consecutive
// correct steps, then stays locked. While locked, every wrong sample raises
// an error pulse; UNLOCK_CNT consecutive wrong samples drop the lock.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   ring_in    in   sampled ring-counter code (WIDTH bits)
//   sample_en  in   qualifies ring_in in the current cycle
//   clr_err    in   synchronous clear of err_count
//   idx        out  binary position of the set bit in the last one-hot sample
//   idx_valid  out  one-cycle pulse, idx was updated
//   locked     out  monitor is in LOCKED
//   err        out  one-cycle pulse, sequence error while locked
//   err_count  out  saturating error count (ERRW bits)
module ring_code_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int ERRW       = 8,
  localparam int IW        = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             sample_en,
  input  logic             clr_err,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] last_q;
  logic [GW-1:0]    good_cnt_q;
  logic [BW-1:0]    bad_cnt_q;
  logic [IW-1:0]    idx_q;
  logic             idx_valid_q;
  logic             locked_q;
  logic             err_q;
  logic [ERRW-1:0]  err_count_q;

  logic             is_onehot;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic [GW-1:0]    good_cnt_d;
  logic [BW-1:0]    bad_cnt_d;
  logic [ERRW-1:0]  err_count_d;

  // Position of the set bit; only meaningful for a one-hot input.
  function automatic logic [IW-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = r | IW'(i);
    end
    return r;
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  // A nonzero value with no bit left after clearing its lowest set bit.
  assign is_onehot  = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign expected   = {last_q[WIDTH-2:0], last_q[WIDTH-1]};
  assign match      = (ring_in == expected);
  assign good_cnt_d = good_cnt_q + GW'(1);
  assign bad_cnt_d  = bad_cnt_q + BW'(1);
  // An error in the same cycle as a clear counts as the first new error.
  assign err_count_d = clr_err ? ERRW'(1) : sat_inc(err_count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      last_q      <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      idx_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (clr_err) err_count_q <= '0;

      if (sample_en) begin
        if (is_onehot) begin
          idx_q       <= onehot_to_idx(ring_in);
          idx_valid_q <= 1'b1;
        end

        case (state_q)
          HUNT: begin
            if (is_onehot) begin
              last_q     <= ring_in;
              good_cnt_q <= GW'(1);
              state_q    <= CONFIRM;
            end
          end

          CONFIRM: begin
            if (match) begin
              last_q     <= ring_in;
              good_cnt_q <= good_cnt_d;
              if (good_cnt_d == LOCK_V) begin
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
                bad_cnt_q <= '0;
              end
            end else if (is_onehot) begin
              // Valid but out of sequence: restart confirmation from here.
              last_q     <= ring_in;
              good_cnt_q <= GW'(1);
            end else begin
              state_q <= HUNT;
            end
          end

          LOCKED: begin
            if (match) begin
              last_q    <= ring_in;
              bad_cnt_q <= '0;
            end else begin
              err_q       <= 1'b1;
              bad_cnt_q   <= bad_cnt_d;
              err_count_q <= err_count_d;
              // Resync to a valid code, otherwise flywheel on the prediction.
              last_q      <= is_onehot ? ring_in : expected;
              if (bad_cnt_d == UNLOCK_V) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
              end
            end
          end

          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_code_monitor.sv
module tb_ring_code_monitor;

  localparam int W      = 3;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 2;
  localparam int EW     = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] ring_in = '0;
  logic         sample_en = 1'b0;
  logic         clr_err = 1'b0;
  logic [1:0]   idx;
  logic         idx_valid;
  logic         locked;
  logic         err;
  logic [EW-1:0] err_count;

  ring_code_monitor #(
    .WIDTH(W), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERRW(EW)
  ) dut (
    .clk(clk), .reset(reset), .ring_in(ring_in), .sample_en(sample_en),
    .clr_err(clr_err), .idx(idx), .idx_valid(idx_valid), .locked(locked),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    idx;
    logic          v;
    logic          l;
    logic          e;
    logic [EW-1:0] ec;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 0=HUNT 1=CONFIRM 2=LOCKED
  int m_state = 0, m_last = 0, m_good = 0, m_bad = 0, m_idx = 0, m_ec = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rot(input int v);
    return ((v * 2) % (1 << W)) + (v / (1 << (W - 1)));
  endfunction

  task automatic model(input bit r, input bit en, input int ring, input bit clr);
    exp_t x;
    int   ex;
    bit   oh;
    bit   mt;
    x = '0;
    if (r) begin
      m_state = 0; m_last = 0; m_good = 0; m_bad = 0; m_idx = 0; m_ec = 0;
    end else begin
      if (clr) m_ec = 0;
      if (en) begin
        oh = ($countones(ring) == 1);
        ex = rot(m_last);
        mt = (ring == ex);
        if (oh) begin
          for (int i = 0; i < W; i++) if (ring == (1 << i)) m_idx = i;
          x.v = 1'b1;
        end
        case (m_state)
          0: if (oh) begin m_last = ring; m_good = 1; m_state = 1; end
          1: begin
            if (mt) begin
              m_last = ring; m_good++;
              if (m_good == LOCK) begin m_state = 2; m_bad = 0; end
            end else if (oh) begin
              m_last = ring; m_good = 1;
            end else m_state = 0;
          end
          default: begin
            if (mt) begin
              m_last = ring; m_bad = 0;
            end else begin
              x.e = 1'b1;
              m_bad++;
              m_ec = clr ? 1 : ((m_ec < 255) ? m_ec + 1 : 255);
              m_last = oh ? ring : ex;
              if (m_bad == UNLOCK) m_state = 0;
            end
          end
        endcase
      end
    end
    x.idx = 2'(m_idx);
    x.l   = (m_state == 2);
    x.ec  = EW'(m_ec);
    q.push_back(x);
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input bit r, input bit en, input int ring, input bit clr);
    exp_t x;
    reset = r; sample_en = en; ring_in = W'(ring); clr_err = clr;
    model(r, en, ring, clr);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      x = q.pop_front();
      check("idx", 32'(idx), 32'(x.idx));
      check("idx_valid", 32'(idx_valid), 32'(x.v));
      check("locked", 32'(locked), 32'(x.l));
      check("err", 32'(err), 32'(x.e));
      check("err_count", 32'(err_count), 32'(x.ec));
    end
  endtask

  task automatic acquire();
    step(0, 1, 1, 0); step(0, 1, 2, 0); step(0, 1, 4, 0); step(0, 1, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 2, 1);
    check("reset_locked", 32'(locked), 0);
    check("reset_err_count", 32'(err_count), 0);

    // Lock acquire 001,010,100,001
    acquire();
    check("lock_acquired", 32'(locked), 1);

    // Single resync error: last=001, sample 100, then 001 in sequence
    step(0, 1, 4, 0);
    check("resync_err", 32'(err), 1);
    check("resync_idx", 32'(idx), 2);
    step(0, 1, 1, 0);
    // bad count must be cleared: one more error must not unlock
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    check("bad_cleared_still_locked", 32'(locked), 1);

    // Lock loss: last=010, samples 011,011 (flywheel 100 for second)
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    check("lock_lost", 32'(locked), 0);

    // Gaps: relock, 5 idle cycles with junk on ring_in, then reset mid-lock
    acquire();
    for (int i = 0; i < 5; i++) step(0, 0, (i % 2) ? 7 : 2, 0);
    step(1, 1, 2, 0);
    step(0, 1, 2, 0);
    check("hunt_after_reset", 32'(locked), 0);

    // Random traffic biased toward correct steps
    for (int i = 0; i < 300; i++) begin
      int  rg;
      bit  en;
      en = ($urandom % 5) != 0;
      rg = (($urandom % 4) != 0 && m_last != 0) ? rot(m_last) : int'($urandom_range(0, 7));
      step(0, en, rg, en && (($urandom % 16) == 0));
    end

    // Saturation: reset, lock, then 300 resync errors each followed by a good step
    step(1, 0, 0, 0);
    acquire();
    for (int i = 0; i < 300; i++) begin
      step(0, 1, m_last, 0);
      step(0, 1, rot(m_last), 0);
    end
    check("saturated", 32'(err_count), 255);
    step(0, 1, m_last, 1);
    check("clr_with_err", 32'(err_count), 1);
    step(0, 1, rot(m_last), 1);
    check("clr_alone", 32'(err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
